// File: rtl/key_lock_pkg.sv
// Shared encodings for the keypad code lock: FSM states and
// the function-key values produced by the keypad scanner.
package key_lock_pkg;

    typedef enum logic [1:0] {
        ST_ENTRY   = 2'd0,
        ST_OPEN    = 2'd1,
        ST_SETCODE = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_BS    = 4'hB;
    localparam logic [3:0] KEY_CLR   = 4'hC;
    localparam logic [3:0] KEY_SET   = 4'hD;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

endpackage

// File: rtl/key_code_lock_if.sv
// Key input strobe and lock status bundle between the keypad
// front end (master) and the code lock (slave).
interface key_code_lock_if;

    logic [3:0]  key_data;
    logic        key_flag;
    logic [15:0] disp;
    logic [2:0]  disp_cnt;
    logic        unlock;
    logic        alarm;
    logic        err;
    logic [1:0]  state;

    modport master (
        output key_data, key_flag,
        input  disp, disp_cnt, unlock, alarm, err, state
    );

    modport slave (
        input  key_data, key_flag,
        output disp, disp_cnt, unlock, alarm, err, state
    );

endinterface

// File: rtl/ms_tick.sv
// Free-running modulo-T1MS prescaler; tick is high for one
// clock every T1MS clocks, starting T1MS-1 clocks after reset.
module ms_tick #(
    parameter int T1MS = 50_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int PW = (T1MS > 1) ? $clog2(T1MS) : 1;

    logic [PW-1:0] r_cnt;

    assign tick = (r_cnt == PW'(T1MS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/key_code_lock.sv
// Four-digit keypad code lock with timed unlock, code change
// and alarm lockout after repeated wrong codes.
module key_code_lock
    import key_lock_pkg::*;
#(
    parameter int          T1MS       = 50_000,
    parameter int          UNLOCK_MS  = 5_000,
    parameter int          LOCKOUT_MS = 10_000,
    parameter int          MAX_FAIL   = 3,
    parameter logic [15:0] INIT_CODE  = 16'h1234
) (
    input  logic           clk,
    input  logic           rst_n,
    key_code_lock_if.slave bus
);

    localparam int TMAX = (UNLOCK_MS > LOCKOUT_MS) ? UNLOCK_MS : LOCKOUT_MS;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int FW   = $clog2(MAX_FAIL + 1);

    state_t        r_state, w_state;
    logic [15:0]   r_disp, w_disp, w_ed_disp;
    logic [2:0]    r_cnt, w_cnt, w_ed_cnt;
    logic [15:0]   r_code, w_code;
    logic [FW-1:0] r_fail, w_fail;
    logic [TW-1:0] r_ms, w_ms;
    logic          r_err, w_err;

    logic w_tick, w_open_to, w_lock_to, w_full;
    logic w_dig, w_ent, w_bs, w_clr, w_set;

    ms_tick #(.T1MS(T1MS)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    assign w_dig = bus.key_flag && is_digit(bus.key_data);
    assign w_ent = bus.key_flag && (bus.key_data == KEY_ENTER);
    assign w_bs  = bus.key_flag && (bus.key_data == KEY_BS);
    assign w_clr = bus.key_flag && (bus.key_data == KEY_CLR);
    assign w_set = bus.key_flag && (bus.key_data == KEY_SET);

    assign w_full    = (r_cnt == 3'd4);
    assign w_open_to = w_tick && (r_ms == TW'(UNLOCK_MS - 1));
    assign w_lock_to = w_tick && (r_ms == TW'(LOCKOUT_MS - 1));

    // Buffer editing shared by ENTRY and SETCODE
    always_comb begin
        w_ed_disp = r_disp;
        w_ed_cnt  = r_cnt;
        unique case (1'b1)
            w_dig: begin
                if (!w_full) begin
                    w_ed_disp = {r_disp[11:0], bus.key_data};
                    w_ed_cnt  = r_cnt + 3'd1;
                end
            end
            w_bs: begin
                if (r_cnt != 3'd0) begin
                    w_ed_disp = r_disp >> 4;
                    w_ed_cnt  = r_cnt - 3'd1;
                end
            end
            w_clr: begin
                w_ed_disp = '0;
                w_ed_cnt  = '0;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state = r_state;
        w_disp  = r_disp;
        w_cnt   = r_cnt;
        w_code  = r_code;
        w_fail  = r_fail;
        w_err   = 1'b0;
        w_ms    = r_ms;
        unique case (r_state)
            ST_ENTRY: begin
                if (w_ent) begin
                    w_disp = '0;
                    w_cnt  = '0;
                    if (w_full && (r_disp == r_code)) begin
                        w_state = ST_OPEN;
                        w_fail  = '0;
                    end else begin
                        w_err = 1'b1;
                        if (r_fail != FW'(MAX_FAIL)) begin
                            w_fail = r_fail + 1'b1;
                        end
                        if (w_fail == FW'(MAX_FAIL)) begin
                            w_state = ST_LOCKOUT;
                        end
                    end
                end else begin
                    w_disp = w_ed_disp;
                    w_cnt  = w_ed_cnt;
                end
            end
            ST_OPEN: begin
                // A timeout on the same cycle as a key drops the key
                if (w_open_to || w_clr) begin
                    w_state = ST_ENTRY;
                end else if (w_set) begin
                    w_state = ST_SETCODE;
                    w_disp  = '0;
                    w_cnt   = '0;
                end
            end
            ST_SETCODE: begin
                unique case (1'b1)
                    w_ent: begin
                        if (w_full) begin
                            w_code  = r_disp;
                            w_disp  = '0;
                            w_cnt   = '0;
                            w_state = ST_ENTRY;
                        end
                    end
                    w_clr: begin
                        w_disp  = '0;
                        w_cnt   = '0;
                        w_state = ST_ENTRY;
                    end
                    default: begin
                        w_disp = w_ed_disp;
                        w_cnt  = w_ed_cnt;
                    end
                endcase
            end
            ST_LOCKOUT: begin
                if (w_lock_to) begin
                    w_state = ST_ENTRY;
                    w_fail  = '0;
                    w_disp  = '0;
                    w_cnt   = '0;
                end
            end
        endcase
        if (w_state != r_state) begin
            w_ms = '0;
        end else if (w_tick && (r_state == ST_OPEN || r_state == ST_LOCKOUT)) begin
            w_ms = r_ms + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ENTRY;
            r_disp  <= '0;
            r_cnt   <= '0;
            r_code  <= INIT_CODE;
            r_fail  <= '0;
            r_ms    <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_disp  <= w_disp;
            r_cnt   <= w_cnt;
            r_code  <= w_code;
            r_fail  <= w_fail;
            r_ms    <= w_ms;
            r_err   <= w_err;
        end
    end

    assign bus.disp     = r_disp;
    assign bus.disp_cnt = r_cnt;
    assign bus.unlock   = (r_state == ST_OPEN);
    assign bus.alarm    = (r_state == ST_LOCKOUT);
    assign bus.err      = r_err;
    assign bus.state    = r_state;

endmodule

// File: doc/key_code_lock.md
KEY_CODE_LOCK -- requirements
Module: key_code_lock

Interface
REQ-001 SHALL have parameter T1MS, default 50_000, clk cycles per 1 ms tick (50 MHz clock).
REQ-002 SHALL have parameter UNLOCK_MS, default 5_000, ms that unlock stays high.
REQ-003 SHALL have parameter LOCKOUT_MS, default 10_000, ms of alarm lockout.
REQ-004 SHALL have parameter MAX_FAIL, default 3, consecutive wrong codes that trigger lockout.
REQ-005 SHALL have parameter INIT_CODE, default 16'h1234, power-on code as four BCD nibbles, MS nibble first entered.
REQ-006 clk  input  1  system clock; one clock domain only.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 key_data  input  4  key value from the keypad scanner, valid only while key_flag=1.
REQ-009 key_flag  input  1  one-cycle pulse per debounced key press.
REQ-010 disp  output  16  entry buffer, four nibbles, newest digit in [3:0].
REQ-011 disp_cnt  output  3  digits held in the buffer, 0..4.
REQ-012 unlock  output  1  high while in OPEN.
REQ-013 alarm  output  1  high while in LOCKOUT.
REQ-014 err  output  1  one-cycle pulse on a rejected code.
REQ-015 state  output  2  ENTRY=0, OPEN=1, SETCODE=2, LOCKOUT=3.

Function
REQ-016 SHALL decode keys as: 0-9 digit, A enter, B backspace, C clear/abort, D change-code; E, F and digits outside the accepting states SHALL be ignored.
REQ-017 SHALL act only on cycles with key_flag=1; every output updates on the clock edge after that cycle (1-cycle latency).
REQ-018 Digit with disp_cnt<4: disp <= {disp[11:0],digit}, disp_cnt+1; with disp_cnt=4: ignored, no change.
REQ-019 B with disp_cnt>0: disp <= disp>>4, disp_cnt-1; B with disp_cnt=0: no change.
REQ-020 C in ENTRY or SETCODE: disp=0, disp_cnt=0.
REQ-021 ENTRY, A, disp_cnt=4, disp=code: go to OPEN, fail count=0, buffer cleared.
REQ-022 ENTRY, A, otherwise (short entry or mismatch): err pulse, fail count+1, buffer cleared; if the new fail count equals MAX_FAIL, go to LOCKOUT instead of staying in ENTRY.
REQ-023 OPEN: unlock=1; C returns to ENTRY at once; D goes to SETCODE with buffer cleared; digits, A and B are ignored.
REQ-024 OPEN: after UNLOCK_MS ms ticks, counted from state entry, return to ENTRY on the tick that completes the count.
REQ-025 SETCODE: unlock=0; digits and B per REQ-018/019; A with disp_cnt=4 loads code<=disp, clears the buffer and goes to ENTRY; A with disp_cnt<4 is ignored; C aborts to ENTRY with code unchanged.
REQ-026 LOCKOUT: alarm=1; all keys ignored; after LOCKOUT_MS ticks go to ENTRY with fail count=0 and buffer cleared.
REQ-027 The ms timer SHALL clear on every state entry; the ms tick SHALL free-run from a modulo-T1MS prescaler.
REQ-028 A key_flag in the same cycle as a timeout tick: timeout wins and the key is dropped.
REQ-029 The fail count SHALL saturate at MAX_FAIL and clear on a correct code or on LOCKOUT exit.

Reset
REQ-030 rst_n=0 SHALL immediately force: state=ENTRY, disp=0, disp_cnt=0, unlock=0, alarm=0, err=0, fail count=0, timers=0, prescaler=0, code=INIT_CODE.
REQ-031 Reset asserted mid-entry, in OPEN or in LOCKOUT SHALL discard everything, including any changed code.

Structure
REQ-032 Shared package key_lock_pkg SHALL hold the state encoding and the key constants KEY_ENTER=4'hA, KEY_BS=4'hB, KEY_CLR=4'hC, KEY_SET=4'hD.
REQ-033 The 1 ms prescaler SHALL be a sub-module, ms_tick (ports clk, rst_n, tick), parameterised by T1MS.
REQ-034 Timer width SHALL be sized for the larger of UNLOCK_MS and LOCKOUT_MS.

Verification (T1MS=4, UNLOCK_MS=3, LOCKOUT_MS=5, MAX_FAIL=3, INIT_CODE=16'h1234)
REQ-035 Keys 1,2,3,4,A -> disp steps 0001, 0012, 0123, 1234; state=OPEN and unlock=1 one cycle after A; ENTRY again after 3 ticks.
REQ-036 Keys 1,2,3,5,B,4,A -> disp 1235 then 0123 then 1234; OPEN; the fifth digit in 1,2,3,4,9 is ignored with disp staying 1234.
REQ-037 Three times 9,9,9,9,A -> three err pulses; after the third, state=LOCKOUT and alarm=1; keys 1,2,3,4,A during lockout are ignored; ENTRY after 5 ticks.
REQ-038 Keys 1,2,3,4,A,D,5,6,7,8,A, then 5,6,7,8,A -> OPEN again; a following 1,2,3,4,A gives an err pulse.
REQ-039 rst_n pulsed low while in OPEN with a changed code -> all outputs 0, state=ENTRY, and 1,2,3,4,A opens.
REQ-040 key_flag in the same cycle as the OPEN timeout tick -> state=ENTRY and the key has no effect.
